// File: rtl/wptr_full_ctrl.sv
// Write-side pointer controller for the clock-domain-crossing FIFO.
// Keeps the binary write address and publishes a registered Gray write pointer
// for the read-domain synchronizer. Derives registered full and almost-full
// flags from the synchronized Gray read pointer.
// Optional feature macro: WPTR_OVF_CNT_EN adds the saturating ovf_cnt port,
// which counts write attempts rejected because the FIFO was full.
module wptr_full_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AFULL_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  input  logic [ADDR_W:0]   rptr_sync,
  output logic              full,
  output logic              afull
`ifdef WPTR_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  // Occupancy at or above this level raises afull.
  localparam logic [PW-1:0] AfullLevel = PW'(DEPTH - AFULL_TH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] used;
  logic [PW-1:0] rptr_full_pat;

  // Requests arriving during reset are never acknowledged.
  assign wr_ack = wr_req & ~full_q & ~rst;

  assign waddr = wbin_q[ADDR_W-1:0];
  assign wptr  = wgray_q;
  assign full  = full_q;
  assign afull = afull_q;

  // Next pointer values and flags; flags look at the post-write pointer and
  // the current synchronized read pointer together.
  always_comb begin
    wbin_d  = wbin_q + PW'(wr_ack);
    wgray_d = (wbin_d >> 1) ^ wbin_d;

    rbin         = '0;
    rbin[PW-1]   = rptr_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_sync[i];
    end

    used = wbin_d - rbin;

    // Full when the write pointer has lapped the read pointer exactly once:
    // in Gray form the two MSBs differ and the remaining bits match.
    rptr_full_pat = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};
    full_d        = (wgray_d == rptr_full_pat);
    afull_d       = (used >= AfullLevel);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
    end
  end

`ifdef WPTR_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  assign ovf_cnt = ovf_cnt_q;

  // Saturating count of write attempts made while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (wr_req && full_q && (ovf_cnt_q != 8'hff)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl (ADDR_W=4, AFULL_TH=2).
// Inputs change 2 time units after the rising edge; outputs are sampled
// mid-cycle, well away from the edge.
module tb_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req;
  logic       wr_ack;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic [4:0] rptr_sync;
  logic       full;
  logic       afull;
`ifdef WPTR_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  int total = 0;
  int bad   = 0;

  wptr_full_ctrl #(
    .ADDR_W   (4),
    .AFULL_TH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_ack    (wr_ack),
    .waddr     (waddr),
    .wptr      (wptr),
    .rptr_sync (rptr_sync),
    .full      (full),
    .afull     (afull)
`ifdef WPTR_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one edge; inputs may then be changed.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    wr_req    = 1'b1;
    rptr_sync = 5'b0;
    #1;
    chk("rst_ack", {31'b0, wr_ack}, 32'd0);
    cyc();
    cyc();
    rst    = 1'b0;
    wr_req = 1'b0;
    #1;
  endtask

  logic [4:0] prev;
  logic [4:0] eb;
  logic [4:0] rb;

  initial begin
    // Reset with a pending request.
    do_reset();
    chk("rst_wptr",  {27'b0, wptr}, 32'd0);
    chk("rst_waddr", {28'b0, waddr}, 32'd0);
    chk("rst_full",  {31'b0, full}, 32'd0);
    chk("rst_afull", {31'b0, afull}, 32'd0);
`ifdef WPTR_OVF_CNT_EN
    chk("rst_ovf", {24'b0, ovf_cnt}, 32'd0);
`endif

    // Fill 16 words with the reader idle.
    wr_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("fill_ack", {31'b0, wr_ack}, 32'd1);
      cyc();
      if (i == 13) chk("fill_afull13", {31'b0, afull}, 32'd0);
      if (i == 14) chk("fill_afull14", {31'b0, afull}, 32'd1);
      if (i == 15) chk("fill_full15",  {31'b0, full}, 32'd0);
    end
    #1;
    chk("fill_full",  {31'b0, full}, 32'd1);
    chk("fill_wptr",  {27'b0, wptr}, 32'h18);
    chk("fill_waddr", {28'b0, waddr}, 32'd0);
    chk("fill_noack", {31'b0, wr_ack}, 32'd0);

    // Writes while full are refused.
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ovf_ack", {31'b0, wr_ack}, 32'd0);
      cyc();
    end
    #1;
    chk("ovf_wptr", {27'b0, wptr}, 32'h18);
    chk("ovf_full", {31'b0, full}, 32'd1);
`ifdef WPTR_OVF_CNT_EN
    chk("ovf_cnt3", {24'b0, ovf_cnt}, 32'd3);
`endif
    for (int i = 0; i < 297; i++) cyc();
    #1;
    chk("ovf_wptr300", {27'b0, wptr}, 32'h18);
`ifdef WPTR_OVF_CNT_EN
    chk("ovf_cnt_sat", {24'b0, ovf_cnt}, 32'd255);
`endif

    // Reader advances by one word.
    wr_req    = 1'b0;
    rptr_sync = 5'b00001;
    cyc();
    #1;
    chk("drain_full",  {31'b0, full}, 32'd0);
    chk("drain_afull", {31'b0, afull}, 32'd1);
    wr_req = 1'b1;
    #1;
    chk("drain_ack", {31'b0, wr_ack}, 32'd1);
    cyc();
    wr_req = 1'b0;
    #1;
    chk("refill_full", {31'b0, full}, 32'd1);
    chk("refill_wptr", {27'b0, wptr}, 32'h19);
    chk("refill_waddr", {28'b0, waddr}, 32'd1);

    // Wrap: reader trails the writer by two words.
    do_reset();
    eb     = 5'd0;
    wr_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rb        = (k >= 2) ? 5'(k - 2) : 5'd0;
      rptr_sync = gray(rb);
      prev      = wptr;
      #1;
      chk("wrap_ack", {31'b0, wr_ack}, 32'd1);
      cyc();
      eb = eb + 5'd1;
      #1;
      chk("wrap_wptr",  {27'b0, wptr}, {27'b0, gray(eb)});
      chk("wrap_waddr", {28'b0, waddr}, {28'b0, eb[3:0]});
      chk("wrap_1bit",  $countones(wptr ^ prev), 32'd1);
      chk("wrap_full",  {31'b0, full}, 32'd0);
      chk("wrap_afull", {31'b0, afull}, 32'd0);
    end

    // Write at 15 words while the reader advances by one in the same cycle.
    do_reset();
    wr_req = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    #1;
    chk("sim_pre_full",  {31'b0, full}, 32'd0);
    chk("sim_pre_afull", {31'b0, afull}, 32'd1);
    chk("sim_pre_wptr",  {27'b0, wptr}, 32'h08);
    rptr_sync = 5'b00001;
    #1;
    chk("sim_ack", {31'b0, wr_ack}, 32'd1);
    cyc();
    #1;
    chk("sim_full",  {31'b0, full}, 32'd0);
    chk("sim_afull", {31'b0, afull}, 32'd1);
    chk("sim_wptr",  {27'b0, wptr}, 32'h18);

    // Reset in the middle of traffic.
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", {31'b0, wr_ack}, 32'd0);
    cyc();
    #1;
    chk("mid_rst_wptr",  {27'b0, wptr}, 32'd0);
    chk("mid_rst_waddr", {28'b0, waddr}, 32'd0);
    chk("mid_rst_full",  {31'b0, full}, 32'd0);
    chk("mid_rst_afull", {31'b0, afull}, 32'd0);
    rst    = 1'b0;
    wr_req = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
